// File: rtl/param_processor.sv
// param_processor: parametrised register-file core.
// Instructions are accepted on a valid/ready port and execute in a single cycle.
// Results of OUT leave through a small output FIFO that also uses valid/ready.
// Zero and carry flags are kept, and a HALT state can only be left by reset.
module param_processor #(
  parameter int WIDTH     = 16,
  parameter int NREGS     = 8,
  parameter int OUT_DEPTH = 4,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag_z,
  output logic             flag_c,
  output logic             halted
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] regs_reg [NREGS];
  logic             z_reg;
  logic             c_reg;

  logic [WIDTH-1:0] fifo_mem [OUT_DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] dst_val;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_next;
  logic             write_en;
  logic             c_load;
  logic             c_next;

  // Handshake: ready is deliberately conservative and ignores a same-cycle pop.
  assign in_ready  = ~rst & (state_reg == ST_RUN) & (count_reg < CW'(OUT_DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & (op == OP_OUT);
  assign pop       = out_ready & (count_reg != '0);

  assign src_val   = regs_reg[rs];
  assign dst_val   = regs_reg[rd];

  assign out_valid = (count_reg != '0);
  assign data_out  = out_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign flag_z    = z_reg;
  assign flag_c    = c_reg;
  assign halted    = (state_reg == ST_HALT);

  // ALU: decode the accepted opcode into a register write and flag updates.
  always_comb begin
    sum         = {1'b0, dst_val} + {1'b0, src_val};
    result_next = '0;
    write_en    = 1'b0;
    c_load      = 1'b0;
    c_next      = c_reg;
    if (accept) begin
      case (op)
        OP_LDI: begin
          result_next = data_in;
          write_en    = 1'b1;
        end
        OP_ADD: begin
          result_next = sum[WIDTH-1:0];
          write_en    = 1'b1;
          c_load      = 1'b1;
          c_next      = sum[WIDTH];
        end
        OP_SUB: begin
          result_next = dst_val - src_val;
          write_en    = 1'b1;
          c_load      = 1'b1;
          c_next      = (dst_val < src_val);
        end
        OP_AND: begin
          result_next = dst_val & src_val;
          write_en    = 1'b1;
        end
        OP_XOR: begin
          result_next = dst_val ^ src_val;
          write_en    = 1'b1;
        end
        OP_NOP, OP_OUT, OP_HALT: begin
          write_en = 1'b0;
        end
        default: begin
          write_en = 1'b0;
        end
      endcase
    end
  end

  // Register file write; rd==rs reads the old value because reads are combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_en) begin
      regs_reg[rd] <= result_next;
    end
  end

  // Flags follow the register write; carry only moves on ADD/SUB.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg <= 1'b0;
      c_reg <= 1'b0;
    end else begin
      if (write_en) begin
        z_reg <= (result_next == '0);
      end
      if (c_load) begin
        c_reg <= c_next;
      end
    end
  end

  // Run/halt control: HALT is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else if (accept && (op == OP_HALT)) begin
      state_reg <= ST_HALT;
    end
  end

  // FIFO storage: contents need no reset since data_out is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= src_val;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_param_processor.sv
// Testbench for param_processor: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the core.
module tb_param_processor;

  localparam int W = 16;
  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         flag_z, flag_c, halted;
  logic [2:0]   op, rd, rs;
  logic [W-1:0] data_in, data_out;

  param_processor #(.WIDTH(W), .NREGS(N), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs(rs), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  // Narrow instance for the WIDTH=8, NREGS=4 sweep.
  logic         rst8, in_valid8, in_ready8, out_valid8, out_ready8, z8, c8, h8;
  logic [2:0]   op8;
  logic [1:0]   rd8, rs8;
  logic [7:0]   din8, dout8;

  param_processor #(.WIDTH(8), .NREGS(4), .OUT_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .rd(rd8), .rs(rs8), .data_in(din8),
    .data_out(dout8), .out_valid(out_valid8), .out_ready(out_ready8),
    .flag_z(z8), .flag_c(c8), .halted(h8)
  );

  int checks = 0;
  int fails  = 0;

  // Behavioural model state.
  logic [W-1:0] m_reg [N];
  logic         m_z, m_c, m_halt;
  logic [W-1:0] m_q [$];
  bit           last_acc;

  function automatic bit m_ready();
    return !rst && !m_halt && (m_q.size() < D);
  endfunction

  function automatic logic [W-1:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    bit           acc, pop, r;
    logic [2:0]   o, d, s;
    logic [W-1:0] a, b, imm, res;
    int           sum;
    acc = in_valid && m_ready();
    pop = out_ready && (m_q.size() > 0);
    r = rst; o = op; d = rd; s = rs; imm = data_in;
    @(posedge clk); #1;
    last_acc = acc;
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_q.delete();
      last_acc = 1'b0;
      return;
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      a = m_reg[d]; b = m_reg[s];
      case (o)
        3'd1: begin m_reg[d] = imm; m_z = (imm == 0); end
        3'd2: begin
          sum = int'(a) + int'(b);
          res = W'(sum);
          m_reg[d] = res; m_z = (res == 0); m_c = (sum >= (1 << W));
        end
        3'd3: begin res = a - b; m_reg[d] = res; m_z = (res == 0); m_c = (a < b); end
        3'd4: begin res = a & b; m_reg[d] = res; m_z = (res == 0); end
        3'd5: begin res = a ^ b; m_reg[d] = res; m_z = (res == 0); end
        3'd6: m_q.push_back(b);
        3'd7: m_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic issue(input logic [2:0] o, input int d, input int s, input logic [W-1:0] imm);
    int waited = 0;
    op = o; rd = 3'(d); rs = 3'(s); data_in = imm; in_valid = 1'b1;
    do begin tick(); waited++; end while (!last_acc && waited < 50);
    in_valid = 1'b0;
    checks++;
    if (!last_acc) begin fails++; $display("FAIL issue_timeout op=%0d got=not_accepted exp=accepted", o); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; rd = '0; rs = '0; data_in = '0;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (data_out !== '0) begin fails++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (halted !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin fails++; $display("FAIL reset_flags got=h%b z%b c%b exp=000", halted, flag_z, flag_c); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    issue(3'd1, 1, 0, 16'h0005);
    issue(3'd1, 2, 0, 16'h0003);
    issue(3'd2, 1, 2, '0);
    checks++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin fails++; $display("FAIL basic_add_flags got=z%b c%b exp=z0 c0", flag_z, flag_c); end
    issue(3'd6, 0, 1, '0);
    checks++; if (out_valid !== 1'b1 || data_out !== 16'h0008) begin fails++; $display("FAIL basic_out got=v%b %h exp=v1 0008", out_valid, data_out); end
    checks++; if (data_out !== m_head()) begin fails++; $display("FAIL basic_out_model got=%h exp=%h", data_out, m_head()); end
    tick();
    $display("test_basic done");
  endtask

  task automatic test_carry();
    out_ready = 1'b1;
    issue(3'd1, 0, 0, 16'hFFFF);
    issue(3'd1, 3, 0, 16'h0001);
    issue(3'd2, 0, 3, '0);
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b1) begin fails++; $display("FAIL carry_add_flags got=z%b c%b exp=z1 c1", flag_z, flag_c); end
    issue(3'd3, 0, 3, '0);
    checks++; if (flag_z !== 1'b0 || flag_c !== 1'b1) begin fails++; $display("FAIL carry_sub_flags got=z%b c%b exp=z0 c1", flag_z, flag_c); end
    issue(3'd6, 0, 0, '0);
    checks++; if (out_valid !== 1'b1 || data_out !== 16'hFFFF) begin fails++; $display("FAIL carry_out got=v%b %h exp=v1 ffff", out_valid, data_out); end
    tick(); tick();
    $display("test_carry done");
  endtask

  task automatic test_full();
    int  pops = 0;
    bit  acc5 = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(3'd6, 0, 1, '0);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    op = 3'd6; rs = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_stall cyc=%0d got=%b exp=0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && pops < 5; k++) begin
      if (out_valid === 1'b1) begin
        pops++;
        checks++; if (data_out !== 16'h0008) begin fails++; $display("FAIL full_drain pop=%0d got=%h exp=0008", pops, data_out); end
      end
      checks++; if (in_ready !== m_ready()) begin fails++; $display("FAIL full_ready_track cyc=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      tick();
      if (last_acc) begin in_valid = 1'b0; acc5 = 1'b1; end
    end
    in_valid = 1'b0;
    checks++; if (pops != 5 || !acc5) begin fails++; $display("FAIL full_count got=pops%0d acc%0b exp=pops5 acc1", pops, acc5); end
    $display("test_full done");
  endtask

  task automatic test_halt();
    logic [W-1:0] seen [$];
    out_ready = 1'b0;
    issue(3'd6, 0, 1, '0);
    issue(3'd6, 0, 2, '0);
    issue(3'd7, 0, 0, '0);
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got=%b exp=1", halted); end
    op = 3'd1; rd = 3'd1; data_in = 16'h1234; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL halt_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid === 1'b1) seen.push_back(data_out);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 2 || seen[0] !== 16'h0008 || seen[1] !== 16'h0003) begin
      fails++; $display("FAIL halt_drain got=n%0d %h %h exp=n2 0008 0003", seen.size(),
        (seen.size() > 0) ? seen[0] : 16'h0, (seen.size() > 1) ? seen[1] : 16'h0);
    end
    checks++; if (halted !== 1'b1 || flag_z !== m_z || flag_c !== m_c) begin fails++; $display("FAIL halt_hold got=h%b z%b c%b exp=h1 z%b c%b", halted, flag_z, flag_c, m_z, m_c); end
    $display("test_halt done");
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    issue(3'd1, 1, 0, 16'h0008);
    out_ready = 1'b0;
    issue(3'd6, 0, 1, '0);
    issue(3'd6, 0, 1, '0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre got=%b exp=1", out_valid); end
    rst = 1'b1; op = 3'd1; rd = 3'd2; data_in = 16'h0055; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready_during got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || data_out !== '0) begin fails++; $display("FAIL midrst_fifo got=v%b %h exp=v0 0000", out_valid, data_out); end
    checks++; if (in_ready !== 1'b1 || halted !== 1'b0) begin fails++; $display("FAIL midrst_ready got=r%b h%b exp=r1 h0", in_ready, halted); end
    out_ready = 1'b1;
    issue(3'd6, 0, 1, '0);
    checks++; if (out_valid !== 1'b1 || data_out !== '0) begin fails++; $display("FAIL midrst_r1 got=v%b %h exp=v1 0000", out_valid, data_out); end
    issue(3'd6, 0, 2, '0);
    checks++; if (data_out !== '0) begin fails++; $display("FAIL midrst_r2 got=%h exp=0000", data_out); end
    tick(); tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      issue(3'd1, 5, 0, W'($urandom));
      issue(3'd1, 6, 0, (it == 0) ? 16'h0000 : W'($urandom));
      issue(3'd2, 5, 6, '0);
      checks++; if (flag_z !== m_z || flag_c !== m_c) begin fails++; $display("FAIL b2b_add it=%0d got=z%b c%b exp=z%b c%b", it, flag_z, flag_c, m_z, m_c); end
      issue(3'd3, 6, 5, '0);
      checks++; if (flag_z !== m_z || flag_c !== m_c) begin fails++; $display("FAIL b2b_sub it=%0d got=z%b c%b exp=z%b c%b", it, flag_z, flag_c, m_z, m_c); end
      issue(3'd4, 5, 6, '0);
      issue(3'd5, 6, 5, '0);
      issue(3'd6, 0, 6, '0);
      checks++; if (data_out !== m_head() || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out it=%0d got=v%b %h exp=v1 %h", it, out_valid, data_out, m_head()); end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [W-1:0] exp_d;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_d = m_head();
      checks++; if (data_out !== exp_d) begin fails++; $display("FAIL rand_data_out cyc=%0d got=%h exp=%h", cyc, data_out, exp_d); end
      checks++; if (out_valid !== (m_q.size() > 0)) begin fails++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_q.size() > 0); end
      checks++; if (flag_z !== m_z || flag_c !== m_c) begin fails++; $display("FAIL rand_flags cyc=%0d got=z%b c%b exp=z%b c%b", cyc, flag_z, flag_c, m_z, m_c); end
      checks++; if (halted !== m_halt) begin fails++; $display("FAIL rand_halted cyc=%0d got=%b exp=%b", cyc, halted, m_halt); end
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 6));
      rd        = 3'($urandom);
      rs        = 3'($urandom);
      data_in   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      #1;
      checks++; if (in_ready !== m_ready()) begin fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_ready()); end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    $display("test_random done");
  endtask

  task automatic issue8(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s, input logic [7:0] imm);
    int n = 0;
    op8 = o; rd8 = d; rs8 = s; din8 = imm; in_valid8 = 1'b1;
    while (in_ready8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 20) begin fails++; $display("FAIL sweep_timeout op=%0d got=not_ready exp=ready", o); end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic test_param_sweep();
    rst8 = 1'b1; @(posedge clk); #1; rst8 = 1'b0;
    out_ready8 = 1'b1;
    issue8(3'd1, 2'd3, 2'd0, 8'h80);
    checks++; if (z8 !== 1'b0) begin fails++; $display("FAIL sweep_ldi_z got=%b exp=0", z8); end
    issue8(3'd2, 2'd3, 2'd3, 8'h00);
    checks++; if (z8 !== 1'b1 || c8 !== 1'b1) begin fails++; $display("FAIL sweep_add got=z%b c%b exp=z1 c1", z8, c8); end
    issue8(3'd5, 2'd3, 2'd3, 8'h00);
    checks++; if (z8 !== 1'b1 || c8 !== 1'b1) begin fails++; $display("FAIL sweep_xor got=z%b c%b exp=z1 c1", z8, c8); end
    issue8(3'd6, 2'd0, 2'd3, 8'h00);
    checks++; if (out_valid8 !== 1'b1 || dout8 !== 8'h00) begin fails++; $display("FAIL sweep_out_r3 got=v%b %h exp=v1 00", out_valid8, dout8); end
    issue8(3'd1, 2'd1, 2'd0, 8'hF0);
    issue8(3'd1, 2'd2, 2'd0, 8'h20);
    issue8(3'd3, 2'd1, 2'd2, 8'h00);
    checks++; if (z8 !== 1'b0 || c8 !== 1'b0) begin fails++; $display("FAIL sweep_sub1 got=z%b c%b exp=z0 c0", z8, c8); end
    issue8(3'd6, 2'd0, 2'd1, 8'h00);
    checks++; if (dout8 !== 8'hD0) begin fails++; $display("FAIL sweep_out_r1 got=%h exp=d0", dout8); end
    issue8(3'd3, 2'd2, 2'd1, 8'h00);
    checks++; if (c8 !== 1'b1 || z8 !== 1'b0) begin fails++; $display("FAIL sweep_sub2 got=z%b c%b exp=z0 c1", z8, c8); end
    issue8(3'd6, 2'd0, 2'd2, 8'h00);
    checks++; if (dout8 !== 8'h50) begin fails++; $display("FAIL sweep_out_r2 got=%h exp=50", dout8); end
    $display("test_param_sweep done");
  endtask

  initial begin
    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; rd8 = '0; rs8 = '0; din8 = '0;
    foreach (m_reg[i]) m_reg[i] = '0;
    m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; last_acc = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_full();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/param_processor.md
Name: param_processor

Overview:
Parametrised successor to the 16-bit simple processor core. Executes a stream of register-file instructions, each arriving on a valid/ready port with an immediate on data_in. Results are emitted through an OUT_DEPTH-entry output FIFO with valid/ready. WIDTH and NREGS are configurable, and zero/carry flags and a HALT state are added.

Parameters:
WIDTH, 16, data path and register width (>=4)
NREGS, 8, register count (power of 2, >=2); AW = $clog2(NREGS) is a derived localparam
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction present
in_ready  out  1  instruction accepted when in_valid & in_ready
op  in  3  opcode
rd  in  AW  destination register index
rs  in  AW  source register index
data_in  in  WIDTH  immediate operand (used by LDI only)
data_out  out  WIDTH  FIFO head value
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops head when out_valid & out_ready
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
halted  out  1  core is in HALT

Behaviour:
- Reset, one cycle at rst=1, overriding everything including mid-stream activity:
  - all regs, flags, data_out and FIFO count are 0
  - out_valid=0, halted=0, state=RUN
  - in_ready=0 during the rst cycle
- FSM:
  - RUN -> HALT on accepting op=7.
  - HALT is left only by rst.
- in_ready = (state==RUN) & (fifo_count < OUT_DEPTH). The flag is conservative: it does not rise on a same-cycle pop.
- Execute is single-cycle on accept. The register write is visible to the next accepted instruction, with no hazards and no stalls.
- Opcodes (arithmetic modulo 2^WIDTH; rd==rs is legal and reads the pre-write value):
  - 0 NOP: no state change.
  - 1 LDI: R[rd] = data_in. Sets Z; C unchanged.
  - 2 ADD: {C, R[rd]} = R[rd] + R[rs]. Sets Z and C (C = carry out).
  - 3 SUB: R[rd] = R[rd] - R[rs]. C = 1 iff R[rd] < R[rs] unsigned (borrow). Sets Z.
  - 4 AND: R[rd] &= R[rs]. Sets Z; C unchanged.
  - 5 XOR: R[rd] ^= R[rs]. Sets Z; C unchanged.
  - 6 OUT: push R[rs] into the FIFO. Flags unchanged.
  - 7 HALT: enter HALT. halted=1 from the next cycle.
- Z = (result == 0), registered with the write.
- Output FIFO:
  - A pushed value appears at data_out with out_valid=1 one cycle after the OUT accept when the FIFO was empty. There is no combinational bypass.
  - data_out = head entry while out_valid=1; data_out = 0 while empty.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Pop when empty is ignored.
  - Push when full cannot occur, because in_ready is low.
  - Read and write pointers wrap modulo OUT_DEPTH.
- HALT:
  - in_ready=0 and instructions are ignored.
  - The FIFO keeps draining via out_ready.
  - Registers and flags hold.
- in_valid=0: no state change apart from FIFO pops.

Test Plan:
1. Reset, then LDI R1=0x0005, LDI R2=0x0003, ADD R1,R2, OUT R1, with out_ready=1 -> data_out=0x0008 and out_valid=1 one cycle after the OUT accept; Z=0, C=0.
2. LDI R0=0xFFFF, LDI R3=0x0001, ADD R0,R3 -> R0=0x0000, Z=1, C=1. Then SUB R0,R3 -> R0=0xFFFF, C=1, Z=0. OUT R0 -> 0xFFFF.
3. out_ready=0, issue 5 OUTs of R1=0x0008 with OUT_DEPTH=4:
   - in_ready drops after the 4th push; the 5th instruction is stalled.
   - Raising out_ready yields four values of 0x0008, then the 5th is accepted.
4. HALT followed by a pending LDI R1=0x1234 -> halted=1 and in_ready=0, R1 unchanged. Output FIFO contents queued before HALT still drain in order.
5. Assert rst mid-stream with the FIFO holding 2 entries -> out_valid=0, data_out=0, all regs 0, in_ready=1 on the cycle after rst deasserts.
6. Parameter sweep WIDTH=8, NREGS=4 -> LDI R3=0x80, ADD R3,R3 gives R3=0x00, C=1, Z=1. XOR R3,R3 keeps Z=1 and leaves C unchanged.
